// File: rtl/sram_access_controller.sv
// rtl/sram_access_controller.sv - 32-bit MEM-stage access split into two 16-bit SRAM halves; optional SRAM_BOUND_CHECK_EN
module sram_access_controller #(
  parameter int unsigned ADDR_BASE   = 1024,
  parameter int unsigned WAIT_CYCLES = 5,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_ENIn,
  input  logic               MEM_W_ENIn,
  input  logic [31:0]        addressIn,
  input  logic [31:0]        writeDataIn,
  output logic [31:0]        readDataOut,
  output logic               readyOut,
  output logic               errOut,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic [15:0]        SRAM_DQ_O,
  input  logic [15:0]        SRAM_DQ_I,
  output logic               SRAM_DQ_OE,
  output logic               SRAM_WE_N
);

  // Counter only needs to reach WAIT_CYCLES-1; WAIT_CYCLES >= 2 keeps CW >= 1.
  localparam int unsigned CW = $clog2(WAIT_CYCLES);
  localparam int unsigned WW = SRAM_AW - 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   word_q, word_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            is_write_q, is_write_d;
  logic [15:0]     rd_lo_q, rd_lo_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic            req;
  logic [WW-1:0]   word_trunc;
  logic            out_of_range;
  logic            last_cycle;

  assign req        = MEM_R_ENIn | MEM_W_ENIn;
  assign word_trunc = WW'((addressIn - ADDR_BASE) >> 2);
  assign last_cycle = (cnt_q == CNT_LAST);

`ifdef SRAM_BOUND_CHECK_EN
  // Below the base, or a word index past the end of the SRAM, never reaches the pads.
  assign out_of_range = (addressIn < ADDR_BASE) ||
                        (((addressIn - ADDR_BASE) >> 2) >= (32'd1 << WW));
`else
  assign out_of_range = 1'b0;
`endif

  // Stall only while a request is pending and the word has not finished.
  assign readyOut    = ~req | (state_q == S_DONE);
  assign readDataOut = rdata_q;
  assign errOut      = err_q;

  // Next-state logic: latch the request on leaving IDLE, count wait states, capture read halves.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    rd_lo_d    = rd_lo_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (out_of_range) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            if (!MEM_W_ENIn) rdata_d = '0;
          end else begin
            state_d    = S_LO;
            cnt_d      = '0;
            word_d     = word_trunc;
            wdata_d    = writeDataIn;
            is_write_d = MEM_W_ENIn;
          end
        end
      end
      S_LO: begin
        if (last_cycle) begin
          cnt_d   = '0;
          state_d = S_HI;
          if (!is_write_q) rd_lo_d = SRAM_DQ_I;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HI: begin
        if (last_cycle) begin
          cnt_d   = '0;
          state_d = S_DONE;
          if (!is_write_q) rdata_d = {SRAM_DQ_I, rd_lo_q};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pad drive decoded from registered state; WE_N released on the last cycle for data hold.
  always_comb begin
    SRAM_ADDR  = '0;
    SRAM_DQ_O  = '0;
    SRAM_DQ_OE = 1'b0;
    SRAM_WE_N  = 1'b1;
    if (state_q == S_LO || state_q == S_HI) begin
      SRAM_ADDR = {word_q, (state_q == S_HI)};
      if (is_write_q) begin
        SRAM_DQ_OE = 1'b1;
        SRAM_DQ_O  = (state_q == S_HI) ? wdata_q[31:16] : wdata_q[15:0];
        SRAM_WE_N  = last_cycle;
      end
    end
  end

  // State registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      word_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      rd_lo_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      rd_lo_q    <= rd_lo_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

endmodule
